// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit bus-based processor: instruction layout,
// opcode and time-step encodings, and field-extraction helpers.
package proc_pkg;

    localparam int INSTR_W   = 9;
    localparam int REG_IDX_W = 3;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;
    localparam int X_MSB   = 5;
    localparam int X_LSB   = 3;
    localparam int Y_MSB   = 2;
    localparam int Y_LSB   = 0;

    // Opcodes 100-111 are not listed; they decode as NOP.
    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011
    } opcode_e;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } tstep_e;

    function automatic logic [2:0] ir_opc(input logic [INSTR_W-1:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [REG_IDX_W-1:0] ir_x(input logic [INSTR_W-1:0] ir);
        return ir[X_MSB:X_LSB];
    endfunction

    function automatic logic [REG_IDX_W-1:0] ir_y(input logic [INSTR_W-1:0] ir);
        return ir[Y_MSB:Y_LSB];
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Index-to-one-hot decoder with enable; indices >= N produce an all-zero output.
module onehot_dec #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         en_i,
    input  logic [W-1:0] idx_i,
    output logic [N-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            onehot_o[i] = en_i && (int'(idx_i) == i);
        end
    end

endmodule

// File: rtl/proc_control_fsm.sv
// Control unit for the 9-bit processor: steps T0..T3, decodes IR and drives
// every register load enable and bus-source select of the datapath.
//
// state | meaning
// T0    | idle / fetch: IRin follows Run, advance when Run=1
// T1    | execute mv/mvi/NOP (Done) or load A from Rx for add/sub
// T2    | add/sub: Ry onto bus, G captures A +/- bus
// T3    | add/sub: G written back to Rx (Done)
module proc_control_fsm
    import proc_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Run,
    input  logic [INSTR_W-1:0] IR,
    output logic               IRin,
    output logic [NREG-1:0]    Rin,
    output logic [NREG-1:0]    Rout,
    output logic               Ain,
    output logic               Gin,
    output logic               Gout,
    output logic               DINout,
    output logic               AddSub,
    output logic               Done,
    output logic [1:0]         Tstep_state
);

    tstep_e state_q, state_d;

    logic [2:0]           opc;
    logic [REG_IDX_W-1:0] idx_x, idx_y;
    logic                 is_arith;

    logic                 irin_c, ain_c, gin_c, gout_c, dinout_c, addsub_c, done_c;
    logic                 rin_en, rout_en;
    logic [REG_IDX_W-1:0] rout_idx;
    logic [NREG-1:0]      rin_dec, rout_dec;

    assign opc      = ir_opc(IR);
    assign idx_x    = ir_x(IR);
    assign idx_y    = ir_y(IR);
    assign is_arith = (opc == OP_ADD) || (opc == OP_SUB);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = T0;
        irin_c   = 1'b0;
        ain_c    = 1'b0;
        gin_c    = 1'b0;
        gout_c   = 1'b0;
        dinout_c = 1'b0;
        addsub_c = 1'b0;
        done_c   = 1'b0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rout_idx = idx_y;

        case (state_q)
            T0: begin
                irin_c  = Run;
                state_d = Run ? T1 : T0;
            end
            T1: begin
                case (opc)
                    OP_MV: begin
                        rout_en = 1'b1;
                        rin_en  = 1'b1;
                        done_c  = 1'b1;
                    end
                    OP_MVI: begin
                        dinout_c = 1'b1;
                        rin_en   = 1'b1;
                        done_c   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_en  = 1'b1;
                        rout_idx = idx_x;
                        ain_c    = 1'b1;
                        state_d  = T2;
                    end
                    default: done_c = 1'b1;
                endcase
            end
            T2: begin
                if (is_arith) begin
                    rout_en  = 1'b1;
                    gin_c    = 1'b1;
                    addsub_c = (opc == OP_SUB);
                    state_d  = T3;
                end
            end
            T3: begin
                if (is_arith) begin
                    gout_c = 1'b1;
                    rin_en = 1'b1;
                    done_c = 1'b1;
                end
            end
            default: state_d = T0;
        endcase
    end

    onehot_dec #(.N(NREG), .W(REG_IDX_W)) u_rin_dec (
        .en_i     (rin_en),
        .idx_i    (idx_x),
        .onehot_o (rin_dec)
    );

    onehot_dec #(.N(NREG), .W(REG_IDX_W)) u_rout_dec (
        .en_i     (rout_en),
        .idx_i    (rout_idx),
        .onehot_o (rout_dec)
    );

    // T0 drives IRin straight from Run, so outputs are masked while reset is held.
    assign IRin        = Resetn & irin_c;
    assign Rin         = rin_dec & {NREG{Resetn}};
    assign Rout        = rout_dec & {NREG{Resetn}};
    assign Ain         = Resetn & ain_c;
    assign Gin         = Resetn & gin_c;
    assign Gout        = Resetn & gout_c;
    assign DINout      = Resetn & dinout_c;
    assign AddSub      = Resetn & addsub_c;
    assign Done        = Resetn & done_c;
    assign Tstep_state = Resetn ? state_q : T0;

endmodule

// File: doc/proc_control_fsm.md
Name: proc_control_fsm

Overview:
Control unit for the 9-bit bus-based processor. Sequences the register file, A/G accumulator, add/sub unit and bus multiplexer through time steps T0..T3. Decodes the instruction register and drives every load enable and bus-source select. Sits beside the datapath inside the processor top level and exports Done and Tstep_state for board-level debug.

Parameters:
NREG, 8, number of general registers addressable by 3-bit fields; indices >= NREG are unimplemented.

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous active-low reset
Run  in  1  start request, sampled only in T0
IR  in  9  current instruction register contents: [8:6] opcode, [5:3] X, [2:0] Y
IRin  out  1  IR load enable (IR captures DIN)
Rin  out  NREG  one-hot register load enables
Rout  out  NREG  one-hot register-to-bus selects
Ain  out  1  A register load
Gin  out  1  G register load
Gout  out  1  G-to-bus select
DINout  out  1  DIN-to-bus select
AddSub  out  1  0 = add, 1 = subtract
Done  out  1  one-cycle instruction-complete pulse
Tstep_state  out  2  current time step: 00=T0, 01=T1, 10=T2, 11=T3

Behaviour:
- Clock is Clock; reset is asynchronous, active-low, on Resetn. During reset and in the cycle after release: state T0. While Resetn=0 every output is forced to 0.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub; 100-111 are NOP.
- State register holds T0..T3. All outputs are combinational from state and IR. IR is valid from T1 onward.
- T0: IRin=Run. If Run=1, go to T1; otherwise hold T0.
- T1, mv: Rout[Y], Rin[X], Done; go to T0.
- T1, mvi: DINout, Rin[X], Done; go to T0.
- T1, add/sub: Rout[X], Ain; go to T2.
- T1, NOP: Done only; go to T0.
- T2, add/sub: Rout[Y], Gin, AddSub=1 only for sub; go to T3.
- T3, add/sub: Gout, Rin[X], Done; go to T0.
- Latency from Run sampled high in T0 to Done: 1 cycle for mv, mvi and NOP; 3 cycles for add/sub.
- Run is ignored outside T0. Deasserting it mid-instruction does not abort. Back-to-back instructions: Done in T1 or T3 is followed by T0 the next cycle; with Run=1 there, IRin=1 and no idle gap.
- Bus exclusivity: at most one of {any Rout bit, Gout, DINout} is high in any cycle. Rin and Rout are one-hot or zero.
- Index X >= NREG: Rin stays zero and the instruction still completes with its normal timing. Index Y >= NREG: Rout stays zero and the bus is undriven by this block.
- AddSub is 0 in every cycle other than T2 of sub.
- Reset asserted in any state: state returns to T0 immediately and outputs are forced to 0. A partially executed instruction is abandoned and no Done is issued.
- Unreachable state encodings cannot occur with the 2-bit state register. The default branch goes to T0 with all outputs at 0.

Decomposition:
- Package proc_pkg: opcode enum (OP_MV, OP_MVI, OP_ADD, OP_SUB), tstep enum (T0..T3, 2-bit), IR field bit positions, instruction width 9.
- Shared with the datapath and the processor top level.
- One sub-module, onehot_dec, parameterised N-way decoder with an enable input (3-bit index to NREG one-hot). Used twice, for Rin and Rout.

Test Plan:
- Reset: drive Resetn=0 while in T2 of an add → Tstep_state=00 immediately, all outputs 0. Release with Run=0 → stays T0, IRin=0, Done never asserts.
- mvi R0: Run=1 in T0, IR=9'b001_000_000 in T1 → T0 IRin=1; T1 DINout=1, Rin=8'h01, Done=1; next cycle Tstep_state=00.
- mv R1,R0: IR=9'b000_001_000 → T1 Rout=8'h01, Rin=8'h02, Done=1; no other enable high.
- add R0,R1: IR=9'b010_000_001 → T1 Rout=8'h01, Ain=1. T2 Rout=8'h02, Gin=1, AddSub=0. T3 Gout=1, Rin=8'h01, Done=1. Done occurs exactly 3 cycles after T0.
- sub R1,R0 with Run held high continuously → AddSub=1 only in T2. After T3 Done, the next cycle is T0 with IRin=1. Bus exclusivity assertion holds every cycle.
- NOP and range checks:
  - IR=9'b111_010_011 → T1 Done=1, Rin=0, Rout=0.
  - With NREG=2, mv R5,R0 → Rin=0, Done=1 in T1.
